// File: rtl/vscale_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential imem
// requests under a credit rule, buffers responses in a small FIFO and
// presents the head entry to DX. A redirect flushes the buffer and turns
// every in-flight response into one that is silently dropped.
module vscale_fetch_unit #(
  parameter int XPR_LEN = 32,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XPR_LEN-1:0] RESET_PC = 32'h200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [XPR_LEN-1:0] redirect_PC,
  input  logic               stall_DX,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XPR_LEN-1:0] imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [31:0]        imem_resp_data,
  input  logic               imem_resp_error,
  output logic               inst_valid_IF,
  output logic [31:0]        inst_IF,
  output logic [XPR_LEN-1:0] PC_IF,
  output logic [1:0]         fault_IF,
  output logic               stall_IF
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h13;

  logic [XPR_LEN-1:0] fetch_pc, fetch_pc_n;
  logic [XPR_LEN-1:0] resp_pc, resp_pc_n;
  logic [PTR_W-1:0]   head, head_n, tail, tail_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [OUT_W-1:0]   live_cnt, live_n, drop_cnt, drop_n;
  logic               misalign, misalign_n;
  logic               stale_req, stale_n;
  logic               req_valid_n;
  logic [XPR_LEN-1:0] req_addr_n;

  logic [XPR_LEN-1:0] buf_pc   [BUF_DEPTH];
  logic [31:0]        buf_data [BUF_DEPTH];
  logic               buf_err  [BUF_DEPTH];

  logic hs, hs_live, hs_stale, resp_live, buf_pop, buf_valid;

  // A stale request is one raised before a redirect; its reply is junk.
  assign hs        = imem_req_valid & imem_req_ready;
  assign hs_live   = hs & ~stale_req;
  assign hs_stale  = hs & stale_req;
  assign resp_live = imem_resp_valid & (drop_cnt == '0) & ~redirect;
  assign buf_valid = (count != '0);
  assign buf_pop   = buf_valid & ~misalign & ~stall_DX & ~redirect;

  // Next-state bookkeeping for PCs, FIFO pointers and in-flight counters.
  always_comb begin
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    head_n     = head;
    tail_n     = tail;
    count_n    = count;
    live_n     = live_cnt;
    drop_n     = drop_cnt;
    misalign_n = misalign;
    stale_n    = stale_req;
    if (redirect) begin
      fetch_pc_n = redirect_PC;
      resp_pc_n  = redirect_PC;
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
      live_n     = '0;
      drop_n     = drop_cnt + live_cnt + OUT_W'(hs) - OUT_W'(imem_resp_valid);
      misalign_n = (redirect_PC[1:0] != 2'b00);
      stale_n    = imem_req_valid & ~hs;
    end else begin
      if (hs_live) fetch_pc_n = fetch_pc + XPR_LEN'(4);
      if (resp_live) begin
        resp_pc_n = resp_pc + XPR_LEN'(4);
        tail_n    = tail + PTR_W'(1);
      end
      if (buf_pop) head_n = head + PTR_W'(1);
      count_n = count + CNT_W'(resp_live) - CNT_W'(buf_pop);
      live_n  = live_cnt + OUT_W'(hs_live) - OUT_W'(resp_live);
      drop_n  = drop_cnt + OUT_W'(hs_stale) - OUT_W'(imem_resp_valid & (drop_cnt != '0));
      stale_n = stale_req & ~hs;
    end
  end

  // Hold an unaccepted request; otherwise raise one if credits allow.
  always_comb begin
    req_valid_n = 1'b0;
    req_addr_n  = imem_req_addr;
    if (imem_req_valid && !hs) begin
      req_valid_n = 1'b1;
    end else if (!misalign_n
                 && (int'(count_n) + int'(live_n) < BUF_DEPTH)
                 && (int'(live_n) + int'(drop_n) < MAX_OUTSTANDING)) begin
      req_valid_n = 1'b1;
      req_addr_n  = fetch_pc_n;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      live_cnt       <= '0;
      drop_cnt       <= '0;
      misalign       <= 1'b0;
      stale_req      <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
    end else begin
      fetch_pc       <= fetch_pc_n;
      resp_pc        <= resp_pc_n;
      head           <= head_n;
      tail           <= tail_n;
      count          <= count_n;
      live_cnt       <= live_n;
      drop_cnt       <= drop_n;
      misalign       <= misalign_n;
      stale_req      <= stale_n;
      imem_req_valid <= req_valid_n;
      imem_req_addr  <= req_addr_n;
    end
  end

  // FIFO storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (resp_live) begin
      buf_pc[tail]   <= resp_pc;
      buf_data[tail] <= imem_resp_data;
      buf_err[tail]  <= imem_resp_error;
    end
  end

  // Head presentation: misaligned target wins, then FIFO head, else NOP.
  always_comb begin
    inst_valid_IF = misalign | buf_valid;
    inst_IF       = NOP;
    PC_IF         = fetch_pc;
    fault_IF      = 2'b00;
    if (misalign) begin
      fault_IF = 2'b10;
    end else if (buf_valid) begin
      inst_IF  = buf_data[head];
      PC_IF    = buf_pc[head];
      fault_IF = buf_err[head] ? 2'b01 : 2'b00;
    end
    stall_IF = ~inst_valid_IF;
  end

  push_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    resp_live |-> (int'(count) < BUF_DEPTH || buf_pop));

  resp_was_requested: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (live_cnt != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Directed bench for vscale_fetch_unit with an in-order 1-cycle imem model.
module tb_vscale_fetch_unit;

  localparam logic [31:0] KEY = 32'hC0DE_0000;
  localparam logic [31:0] NOP = 32'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic        stall_DX;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_error;
  logic        inst_valid_IF;
  logic [31:0] inst_IF;
  logic [31:0] PC_IF;
  logic [1:0]  fault_IF;
  logic        stall_IF;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_q[$];
  logic [31:0] req_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  logic [1:0]  pop_fault_q[$];
  logic        resp_en;
  logic [31:0] err_addr;

  vscale_fetch_unit dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_PC(redirect_PC),
    .stall_DX(stall_DX), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_error(imem_resp_error),
    .inst_valid_IF(inst_valid_IF), .inst_IF(inst_IF), .PC_IF(PC_IF),
    .fault_IF(fault_IF), .stall_IF(stall_IF)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // One clock: log pops and handshakes, cross the edge, then drive the memory reply.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    if (reset && inst_valid_IF && !stall_DX && !redirect) begin
      pop_pc_q.push_back(PC_IF);
      pop_inst_q.push_back(inst_IF);
      pop_fault_q.push_back(fault_IF);
    end
    hs = reset && imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (hs) req_q.push_back(a);
    @(posedge clk);
    #1;
    if (hs) mem_q.push_back(a);
    if (reset && resp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = a ^ KEY;
      imem_resp_error = (a == err_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_error = 1'b0;
    end
  endtask

  // Reset DUT and memory model, then release; returns in cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0;
    redirect_PC = 32'h0;
    stall_DX = 1'b0;
    imem_req_ready = 1'b0;
    resp_en = 1'b0;
    err_addr = 32'h1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_resp_error = 1'b0;
    mem_q.delete(); req_q.delete();
    pop_pc_q.delete(); pop_inst_q.delete(); pop_fault_q.delete();
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
    vectors++; if (inst_valid_IF !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_inst_valid: got %0b want 0", inst_valid_IF); end
    vectors++; if (inst_IF !== NOP) begin miscompares++; $display("[TB] FAIL rst_inst: got %h want %h", inst_IF, NOP); end
    vectors++; if (PC_IF !== 32'h200) begin miscompares++; $display("[TB] FAIL rst_pc: got %h want 00000200", PC_IF); end
    vectors++; if (fault_IF !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_fault: got %b want 00", fault_IF); end
    vectors++; if (stall_IF !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_stall: got %0b want 1", stall_IF); end
    do_reset();
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    // Asynchronous reset in the middle of traffic, memory model reset too.
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    mem_q.delete();
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_req_valid: got %0b want 0", imem_req_valid); end
    vectors++; if (inst_valid_IF !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_inst_valid: got %0b want 0", inst_valid_IF); end
    vectors++; if (PC_IF !== 32'h200) begin miscompares++; $display("[TB] FAIL midrst_pc: got %h want 00000200", PC_IF); end
    vectors++; if (inst_IF !== NOP) begin miscompares++; $display("[TB] FAIL midrst_inst: got %h want %h", inst_IF, NOP); end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL seq_req0: got v=%0b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204) begin miscompares++; $display("[TB] FAIL seq_req1: got v=%0b a=%h want v=1 a=00000204", imem_req_valid, imem_req_addr); end
    vectors++; if (inst_valid_IF !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_cyc2_valid: got %0b want 0", inst_valid_IF); end
    tick();
    vectors++; if (inst_valid_IF !== 1'b1 || PC_IF !== 32'h200) begin miscompares++; $display("[TB] FAIL seq_first: got v=%0b pc=%h want v=1 pc=00000200", inst_valid_IF, PC_IF); end
    vectors++; if (inst_IF !== (32'h200 ^ KEY) || stall_IF !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_first_inst: got %h stall=%0b want %h stall=0", inst_IF, stall_IF, 32'h200 ^ KEY); end
    for (int i = 0; i < 40 && pop_pc_q.size() < 6; i++) tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= pop_pc_q.size() || pop_pc_q[i] !== 32'h200 + 32'(4 * i) || pop_inst_q[i] !== ((32'h200 + 32'(4 * i)) ^ KEY)) begin
        miscompares++; $display("[TB] FAIL seq_pop%0d: got %0d pops, want pc=%h", i, pop_pc_q.size(), 32'h200 + 32'(4 * i));
      end
      vectors++;
      if (i >= req_q.size() || req_q[i] !== 32'h200 + 32'(4 * i)) begin
        miscompares++; $display("[TB] FAIL seq_req%0d: got %0d reqs, want addr=%h", i, req_q.size(), 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_fill();
    do_reset();
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 30 && pop_pc_q.size() < 2; i++) tick();
    stall_DX = 1'b1;
    repeat (6) tick();
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_req_valid: got %0b want 0", imem_req_valid); end
    vectors++; if (inst_valid_IF !== 1'b1 || PC_IF !== 32'h208) begin miscompares++; $display("[TB] FAIL stall_head: got v=%0b pc=%h want v=1 pc=00000208", inst_valid_IF, PC_IF); end
    vectors++; if (req_q.size() != 4) begin miscompares++; $display("[TB] FAIL stall_req_count: got %0d want 4", req_q.size()); end
    stall_DX = 1'b0;
    for (int i = 0; i < 40 && pop_pc_q.size() < 8; i++) tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= pop_pc_q.size() || pop_pc_q[i] !== 32'h200 + 32'(4 * i)) begin
        miscompares++; $display("[TB] FAIL stall_pop%0d: got %0d pops, want pc=%h", i, pop_pc_q.size(), 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    imem_req_ready = 1'b1;
    tick(); tick(); tick();
    vectors++; if (imem_req_valid !== 1'b0 || req_q.size() != 2) begin miscompares++; $display("[TB] FAIL rd_credit: got v=%0b reqs=%0d want v=0 reqs=2", imem_req_valid, req_q.size()); end
    resp_en = 1'b1;
    redirect = 1'b1; redirect_PC = 32'h1000;
    tick();
    redirect = 1'b0;
    vectors++; if (inst_valid_IF !== 1'b0 || PC_IF !== 32'h1000) begin miscompares++; $display("[TB] FAIL rd_after: got v=%0b pc=%h want v=0 pc=00001000", inst_valid_IF, PC_IF); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_drop_block: got %0b want 0", imem_req_valid); end
    for (int i = 0; i < 30 && pop_pc_q.size() < 2; i++) tick();
    vectors++; if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 32'h1000 || pop_inst_q[0] !== (32'h1000 ^ KEY)) begin miscompares++; $display("[TB] FAIL rd_pop0: got %0d pops, want pc=00001000", pop_pc_q.size()); end
    vectors++; if (pop_pc_q.size() < 2 || pop_pc_q[1] !== 32'h1004) begin miscompares++; $display("[TB] FAIL rd_pop1: got %0d pops, want pc=00001004", pop_pc_q.size()); end
    vectors++; if (req_q.size() < 3 || req_q[2] !== 32'h1000) begin miscompares++; $display("[TB] FAIL rd_req_new: got %0d reqs, want third=00001000", req_q.size()); end
  endtask

  task automatic test_pending_redirect();
    int n0;
    do_reset();
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 20 && !(imem_req_valid && imem_req_addr == 32'h208); i++) tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h208) begin miscompares++; $display("[TB] FAIL pend_seen: got v=%0b a=%h want v=1 a=00000208", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b0;
    tick(); tick();
    n0 = pop_pc_q.size();
    redirect = 1'b1; redirect_PC = 32'h1000;
    tick();
    redirect = 1'b0;
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h208) begin miscompares++; $display("[TB] FAIL pend_hold1: got v=%0b a=%h want v=1 a=00000208", imem_req_valid, imem_req_addr); end
    tick();
    vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h208) begin miscompares++; $display("[TB] FAIL pend_hold2: got v=%0b a=%h want v=1 a=00000208", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 30 && pop_pc_q.size() < n0 + 2; i++) tick();
    vectors++; if (req_q.size() < 4 || req_q[2] !== 32'h208 || req_q[3] !== 32'h1000) begin miscompares++; $display("[TB] FAIL pend_req_seq: got %0d reqs, want 00000208 then 00001000", req_q.size()); end
    vectors++; if (pop_pc_q.size() < n0 + 2 || pop_pc_q[n0] !== 32'h1000 || pop_pc_q[n0 + 1] !== 32'h1004) begin miscompares++; $display("[TB] FAIL pend_pops: got %0d pops after redirect, want 00001000 00001004", pop_pc_q.size() - n0); end
  endtask

  task automatic test_fault();
    int n0;
    do_reset();
    err_addr = 32'h20C;
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 40 && pop_pc_q.size() < 5; i++) tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= pop_pc_q.size() || pop_pc_q[i] !== 32'h200 + 32'(4 * i) || pop_fault_q[i] !== ((i == 3) ? 2'b01 : 2'b00)) begin
        miscompares++; $display("[TB] FAIL flt_pop%0d: got %0d pops, want pc=%h fault=%0d", i, pop_pc_q.size(), 32'h200 + 32'(4 * i), (i == 3) ? 1 : 0);
      end
    end
    redirect = 1'b1; redirect_PC = 32'h1002;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (inst_valid_IF !== 1'b1 || fault_IF !== 2'b10 || PC_IF !== 32'h1002 || inst_IF !== NOP || imem_req_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL mis_cyc%0d: got v=%0b f=%b pc=%h inst=%h req=%0b want v=1 f=10 pc=00001002 inst=00000013 req=0", i, inst_valid_IF, fault_IF, PC_IF, inst_IF, imem_req_valid);
      end
      tick();
    end
    n0 = pop_pc_q.size();
    redirect = 1'b1; redirect_PC = 32'h1000;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 30 && pop_pc_q.size() < n0 + 2; i++) tick();
    vectors++; if (pop_pc_q.size() < n0 + 2 || pop_pc_q[n0] !== 32'h1000 || pop_fault_q[n0] !== 2'b00 || pop_pc_q[n0 + 1] !== 32'h1004) begin miscompares++; $display("[TB] FAIL mis_resume: got %0d pops after redirect, want 00001000 00001004 fault 00", pop_pc_q.size() - n0); end
  endtask

  task automatic test_wrap_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    resp_en = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_PC = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    vectors++; if (inst_valid_IF !== 1'b0 || PC_IF !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_drop: got v=%0b pc=%h want v=0 pc=fffffffc", inst_valid_IF, PC_IF); end
    for (int i = 0; i < 30 && pop_pc_q.size() < 3; i++) tick();
    vectors++; if (pop_pc_q.size() < 3 || pop_pc_q[0] !== 32'hFFFF_FFFC || pop_inst_q[0] !== (32'hFFFF_FFFC ^ KEY)) begin miscompares++; $display("[TB] FAIL wrap_pop0: got %0d pops, want fffffffc", pop_pc_q.size()); end
    vectors++; if (pop_pc_q.size() < 3 || pop_pc_q[1] !== 32'h0 || pop_pc_q[2] !== 32'h4) begin miscompares++; $display("[TB] FAIL wrap_pop12: got %0d pops, want 00000000 00000004", pop_pc_q.size()); end
    vectors++; if (req_q.size() < 4 || req_q[2] !== 32'hFFFF_FFFC || req_q[3] !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_reqs: got %0d reqs, want fffffffc then 00000000", req_q.size()); end
  endtask

  // Scenario sequence and summary.
  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_PC = 32'h0;
    stall_DX = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_resp_error = 1'b0;
    resp_en = 1'b0;
    err_addr = 32'h1;
    #1;
    test_reset();
    test_sequential();
    test_stall_fill();
    test_redirect_drop();
    test_pending_redirect();
    test_fault();
    test_wrap_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
